// File: rtl/mac_result_serializer.sv
// Buffers 16-bit MAC results in a small FIFO and streams each one out as two
// bytes (high byte first) over a valid/ready pad interface, counting overflow drops.
module mac_result_serializer #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic                     cap,
  input  logic [DATA_W-1:0]        mac_out,
  output logic [OUT_W-1:0]         out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf,
  output logic [OUT_W-1:0]         io_oeb,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [OUT_W-1:0]    io_oeb_q, io_oeb_d;

  logic empty, full, pop, push, drop, xfer, clr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign clr   = clken & clr_ovf;

  // Handshake: a byte moves when out_valid & out_ready & clken at a rising
  // edge; out_valid/out_byte/out_last are decoded from state and word_q only,
  // so they stay stable until that transfer happens.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = '0;
    case (state_q)
      HI: begin
        out_valid = 1'b1;
        out_byte  = word_q[DATA_W-1:OUT_W];
      end
      LO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_byte  = word_q[OUT_W-1:0];
      end
      default: ;
    endcase
  end

  assign xfer = out_valid & out_ready & clken;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clken && !empty) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr_q];
          state_d = HI;
        end
      end
      HI: begin
        if (xfer) state_d = LO;
      end
      LO: begin
        // Reload straight from the FIFO so consecutive words have no bubble.
        if (xfer) begin
          if (!empty) begin
            pop     = 1'b1;
            word_d  = mem_q[rd_ptr_q];
            state_d = HI;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a capture when an entry leaves on the same edge.
  assign push = clken & cap & (~full | pop);
  assign drop = clken & cap & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = mac_out;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop on the same edge as a clear wins and starts the count again at 1.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr)                      drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  assign io_oeb_d = clken ? '0 : io_oeb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      io_oeb_q   <= '1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      io_oeb_q   <= io_oeb_d;
      mem_q      <= mem_d;
    end
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign io_oeb     = io_oeb_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: expected bytes are queued when
// words are captured and checked by a monitor as the DUT hands them over.
module tb_mac_result_serializer;

  logic        clk;
  logic        rst;
  logic        clken;
  logic        cap;
  logic [15:0] mac_out;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        clr_ovf;
  logic [7:0]  io_oeb;
  logic [1:0]  dbg_state;

  // {last, byte}
  logic [8:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;

  mac_result_serializer #(.DATA_W(16), .OUT_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .cap        (cap),
    .mac_out    (mac_out),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .clr_ovf    (clr_ovf),
    .io_oeb     (io_oeb),
    .dbg_state  (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  task automatic drain(input int max_cycles);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      step();
      cyc++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: inputs are stable from posedge+1 to the next posedge,
  // so a handshake seen at negedge completes on the following rising edge.
  always @(negedge clk) begin
    if (rst && clken && out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_byte: observed %0h expected none", {out_last, out_byte});
      end
      if (exp_q.size() != 0) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert ({out_last, out_byte} === e) else begin
          n_err++;
          $error("FAIL out_byte_last: observed %0h expected %0h", {out_last, out_byte}, e);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; clken = 1'b1; cap = 1'b0; mac_out = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;

    // reset state
    repeat (3) step();
    check("rst_valid",    out_valid, 0);
    check("rst_byte",     out_byte, 0);
    check("rst_last",     out_last, 0);
    check("rst_count",    fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropcnt",  drop_cnt, 0);
    check("rst_oeb",      io_oeb, 8'hFF);
    check("rst_state",    dbg_state, S_IDLE);
    rst = 1'b1;
    step();
    check("oeb_enabled", io_oeb, 8'h00);

    // 1: single word, consumer always ready
    out_ready = 1'b1;
    mac_out = 16'hA55A; cap = 1'b1; expect_word(16'hA55A);
    step();
    cap = 1'b0;
    check("t1_count_after_cap", fifo_count, 1);
    check("t1_valid_latency0",  out_valid, 0);
    step();
    check("t1_valid_hi", out_valid, 1);
    check("t1_byte_hi",  out_byte, 8'hA5);
    check("t1_last_hi",  out_last, 0);
    step();
    check("t1_byte_lo",  out_byte, 8'h5A);
    check("t1_last_lo",  out_last, 1);
    step();
    check("t1_valid_end", out_valid, 0);
    check("t1_queue",     exp_q.size(), 0);

    // 2: back-pressure in HI
    out_ready = 1'b0;
    mac_out = 16'h1234; cap = 1'b1; expect_word(16'h1234);
    step();
    cap = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_byte",  out_byte, 8'h12);
      check("t2_hold_last",  out_last, 0);
      step();
    end
    out_ready = 1'b1;
    drain(10);
    check("t2_valid_end", out_valid, 0);

    // 3: overflow with six captures and the consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      mac_out = 16'(i); cap = 1'b1;
      if (i <= 5) expect_word(16'(i));
      step();
    end
    cap = 1'b0;
    check("t3_count_full", fifo_count, 4);
    check("t3_overflow",   overflow, 1);
    check("t3_dropcnt",    drop_cnt, 1);
    check("t3_state",      dbg_state, S_HI);
    check("t3_byte",       out_byte, 8'h00);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t3_clr_overflow", overflow, 0);
    check("t3_clr_dropcnt",  drop_cnt, 0);
    mac_out = 16'hEEEE; cap = 1'b1; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t3_drop_wins_ovf", overflow, 1);
    check("t3_drop_wins_cnt", drop_cnt, 1);
    step();
    cap = 1'b0;
    check("t3_dropcnt_2", drop_cnt, 2);
    check("t3_count_hold", fifo_count, 4);

    // 4: capture while full coinciding with the LO transfer
    out_ready = 1'b1;
    step();
    check("t4_state_lo", dbg_state, S_LO);
    check("t4_count_lo", fifo_count, 4);
    mac_out = 16'h0007; cap = 1'b1; expect_word(16'h0007);
    step();
    cap = 1'b0;
    check("t4_count_stays", fifo_count, 4);
    check("t4_no_drop",     drop_cnt, 2);
    check("t4_next_hi",     dbg_state, S_HI);
    check("t4_next_valid",  out_valid, 1);
    check("t4_next_last",   out_last, 0);
    drain(40);
    check("t4_valid_end", out_valid, 0);
    check("t4_count_end", fifo_count, 0);

    // 5: clock enable low freezes everything
    out_ready = 1'b0;
    mac_out = 16'hBEEF; cap = 1'b1; expect_word(16'hBEEF);
    step();
    cap = 1'b0;
    step();
    clken = 1'b0; out_ready = 1'b1; cap = 1'b1; mac_out = 16'hDEAD; clr_ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_state", dbg_state, S_HI);
      check("t5_byte",  out_byte, 8'hBE);
      check("t5_count", fifo_count, 0);
      check("t5_ovf",   overflow, 1);
    end
    clken = 1'b1; cap = 1'b0; clr_ovf = 1'b0;
    drain(10);
    check("t5_valid_end", out_valid, 0);

    // 6: reset while in LO with three words queued
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      mac_out = {4{4'(i)}}; cap = 1'b1;
      step();
    end
    cap = 1'b0;
    check("t6_count_pre", fifo_count, 3);
    exp_q.push_back({1'b0, 8'h11});
    out_ready = 1'b1;
    step();
    check("t6_state_lo", dbg_state, S_LO);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_oeb",   io_oeb, 8'hFF);
    step();
    rst = 1'b1;
    repeat (10) step();
    check("t6_no_stale_valid", out_valid, 0);
    check("t6_no_stale_count", fifo_count, 0);
    check("t6_queue",          exp_q.size(), 0);
    check("t6_oeb",            io_oeb, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
